ex_md_stage: RTL and testbench
==============================

EX_MD_STAGE -- requirements
Module: ex_md_stage

Interface
REQ-001 The module SHALL have parameter W, default 32, giving the operand and HI/LO width (any even value 8..64).
REQ-002 The module SHALL have parameter MUL_LAT, default 2, giving the multiply latency in cycles (1..4).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The module SHALL have port stall, input, StallBus bits: pipeline stall vector; bit 2 is the EX stage, bit 3 is the MEM stage.
REQ-006 The module SHALL have port flush, input, 1 bit: pipeline flush.
REQ-007 The module SHALL have port md_op, input, 3 bits: 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 treated as none.
REQ-008 The module SHALL have ports src_a and src_b, input, W bits each: operands (dividend/divisor; MTHI/MTLO use src_a).
REQ-009 The module SHALL have ports hi and lo, output, W bits each: architectural HI/LO registers.
REQ-010 The module SHALL have port stallreq_from_ex, output, 1 bit: pipeline stall request.
REQ-011 The module SHALL have port md_busy, output, 1 bit: FSM not in IDLE.

Function
REQ-012 Input register {md_op, src_a, src_b} SHALL load a bubble (md_op=000) when flush=1, or when stall[2]=Stop and stall[3]=NoStop; load inputs when stall[2]=NoStop; otherwise hold.
REQ-013 An issued flag SHALL be cleared whenever the input register loads, and set when an operation starts; a held register with issued=1 SHALL NOT restart.
REQ-014 FSM states SHALL be IDLE, BUSY and DONE.
REQ-015 IDLE->BUSY SHALL occur on the issue cycle: registered op is mul/div, issued=0, flush=0; operands/magnitudes are captured and a counter is loaded with L-1 (L=MUL_LAT for mul, W+1 for div).
REQ-016 BUSY SHALL decrement the counter each cycle and go to DONE when it reaches 0; with L-1=0 the FSM SHALL go directly IDLE->DONE.
REQ-017 DONE SHALL write the result to HI/LO at the end of the cycle and go to IDLE.
REQ-018 stallreq_from_ex SHALL be high combinationally on the issue cycle and throughout BUSY (exactly L cycles) and low in DONE and IDLE.
REQ-019 Multiply SHALL form the 2W-bit signed (MULT) or unsigned (MULTU) product: HI=upper W bits, LO=lower W bits.
REQ-020 Divide SHALL be restoring, 1 quotient bit per BUSY cycle, on magnitudes; quotient sign = sign(a) XOR sign(b); remainder sign = sign(a); LO=quotient, HI=remainder.
REQ-021 Divide by zero SHALL take full latency and give LO=all ones, HI=src_a.
REQ-022 MTHI/MTLO SHALL write HI or LO at the end of the cycle the op sits in the register, with no stall and no FSM change, and only once per register load.
REQ-023 flush SHALL force the FSM to IDLE at the next edge, discard the result, leave HI/LO unchanged and drop stallreq_from_ex in the flush cycle.
REQ-024 Operations SHALL be serialised: a new op is ignored until the FSM returns to IDLE (guaranteed by the stall).

Reset
REQ-025 On rst=0, immediately and independent of clk, the module SHALL clear the input register, HI, LO, counter and issued flag, set FSM=IDLE, and drive stallreq_from_ex=0 and md_busy=0.
REQ-026 An operation in flight at reset SHALL be lost with no HI/LO write.

Verification (W=32, MUL_LAT=2)
REQ-027 MULT a=0xFFFFFFFF, b=2 -> stallreq high 2 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFE after DONE.
REQ-028 DIVU 100/7 -> stallreq high 33 cycles; LO=14, HI=2.
REQ-029 DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 5/0 -> LO=0xFFFFFFFF, HI=5.
REQ-030 DIV with flush on BUSY cycle 10 -> stallreq low in that cycle, IDLE next cycle, HI/LO unchanged.
REQ-031 rst low mid-DIV (asynchronous, between edges) -> hi=lo=0 and stallreq=0 immediately; FSM IDLE.
REQ-032 MTHI 0x1234 held 3 cycles by a MEM stall, then MULTU 3*4 held by an external stall in DONE -> HI=0x1234, then HI=0, LO=12, with no re-issue.

Source files
------------

// File: rtl/ex_md_stage.sv
// ex_md_stage: EX-stage multiply/divide unit owning the HI/LO registers.
// Multi-cycle ops stall the pipeline; MTHI/MTLO complete in one cycle.
module ex_md_stage #(
  parameter int W = 32,
  parameter int MUL_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [5:0]   stall,
  input  logic         flush,
  input  logic [2:0]   md_op,
  input  logic [W-1:0] src_a,
  input  logic [W-1:0] src_b,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         stallreq_from_ex,
  output logic         md_busy
);
  localparam int CW = $clog2(W + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [2:0] op_r;
  logic [W-1:0] a_r, b_r, ca, cb, quo, rem, q_s, r_s, res_hi, res_lo;
  logic [CW-1:0] cnt;
  logic issued, is_mul, is_div, issue, ld_bub, ld_in, mt_we;
  logic k_div, k_sgn, sa, sb, dbz;
  logic [2*W-1:0] ea, eb, prod;
  logic [W+1:0] diff;
  logic unused;
  assign is_mul = op_r == 3'b001 || op_r == 3'b010;
  assign is_div = op_r == 3'b011 || op_r == 3'b100;
  assign ld_bub = flush || (stall[2] && !stall[3]);
  assign ld_in  = !ld_bub && !stall[2];
  assign issue  = state == IDLE && (is_mul || is_div) && !issued && !flush;
  assign mt_we  = (op_r == 3'b101 || op_r == 3'b110) && !issued && !flush;
  // Restoring step: trial-subtract the divisor magnitude from the shifted partial remainder
  assign diff = {1'b0, rem, quo[W-1]} - {2'b00, cb};
  assign ea = {{W{k_sgn & ca[W-1]}}, ca};
  assign eb = {{W{k_sgn & cb[W-1]}}, cb};
  assign prod = ea * eb;
  assign dbz = cb == '0;
  assign q_s = (sa ^ sb) ? -quo : quo;
  assign r_s = sa ? -rem : rem;
  assign res_lo = k_div ? (dbz ? {W{1'b1}} : q_s) : prod[W-1:0];
  assign res_hi = k_div ? (dbz ? ca : r_s) : prod[2*W-1:W];
  assign unused = ^{stall[5:4], stall[1:0], diff[W]};
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = flush ? IDLE :
               state == IDLE ? (issue ? ((is_div || MUL_LAT > 1) ? BUSY : DONE) : IDLE) :
               state == BUSY ? (cnt == CW'(1) ? DONE : BUSY) : IDLE;
  end
  always_comb begin
    stallreq_from_ex = issue || (state == BUSY && !flush);
    md_busy = state != IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      op_r <= '0;
      a_r <= '0;
      b_r <= '0;
      issued <= 1'b0;
      hi <= '0;
      lo <= '0;
      cnt <= '0;
      ca <= '0;
      cb <= '0;
      quo <= '0;
      rem <= '0;
      k_div <= 1'b0;
      k_sgn <= 1'b0;
      sa <= 1'b0;
      sb <= 1'b0;
    end else begin
      if (ld_bub || ld_in) begin
        op_r <= ld_in ? md_op : 3'b000;
        a_r <= ld_in ? src_a : '0;
        b_r <= ld_in ? src_b : '0;
        issued <= 1'b0;
      end else if (issue || mt_we) issued <= 1'b1;
      if (issue) begin
        ca <= a_r;
        cb <= (op_r == 3'b011 && b_r[W-1]) ? -b_r : b_r;
        quo <= (op_r == 3'b011 && a_r[W-1]) ? -a_r : a_r;
        rem <= '0;
        k_div <= is_div;
        k_sgn <= op_r == 3'b001;
        sa <= op_r == 3'b011 && a_r[W-1];
        sb <= op_r == 3'b011 && b_r[W-1];
        cnt <= is_div ? CW'(W) : CW'(MUL_LAT - 1);
      end else if (state == BUSY) begin
        cnt <= cnt - 1'b1;
        if (k_div) begin
          quo <= {quo[W-2:0], ~diff[W+1]};
          rem <= diff[W+1] ? {rem[W-2:0], quo[W-1]} : diff[W-1:0];
        end
      end
      if (mt_we && op_r == 3'b101) hi <= a_r;
      if (mt_we && op_r == 3'b110) lo <= a_r;
      if (state == DONE && !flush) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end
endmodule

// File: tb/tb_ex_md_stage.sv
// tb_ex_md_stage: directed plus random checks of ex_md_stage against
// an arithmetic reference model of HI/LO and stall latency.
module tb_ex_md_stage;
  logic clk = 1'b0, rst = 1'b0, flush = 1'b0;
  logic [5:0] ext = '0, stall;
  logic [2:0] md_op = '0;
  logic [31:0] src_a = '0, src_b = '0, hi, lo;
  logic stallreq_from_ex, md_busy;
  int errors = 0, checks = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  // The EX stall request stalls the front of the pipe, as the hazard unit would
  assign stall = stallreq_from_ex ? (ext | 6'b001111) : ext;
  always #5 clk = ~clk;
  ex_md_stage #(.W(32), .MUL_LAT(2)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .md_op(md_op),
    .src_a(src_a), .src_b(src_b), .hi(hi), .lo(lo),
    .stallreq_from_ex(stallreq_from_ex), .md_busy(md_busy)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      $error("check %s", tag);
    end
  endtask
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int lat);
    logic [63:0] p, q, r;
    longint sa_, sb_, ua, ub;
    sa_ = longint'($signed(a));
    sb_ = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    lat = 0;
    case (op)
      3'd1: begin p = sa_ * sb_; m_hi = p[63:32]; m_lo = p[31:0]; lat = 2; end
      3'd2: begin p = ua * ub; m_hi = p[63:32]; m_lo = p[31:0]; lat = 2; end
      3'd3, 3'd4: begin
        lat = 33;
        if (b == 0) begin m_hi = a; m_lo = 32'hFFFFFFFF; end
        else begin
          q = (op == 3'd3) ? sa_ / sb_ : ua / ub;
          r = (op == 3'd3) ? sa_ % sb_ : ua % ub;
          m_hi = r[31:0];
          m_lo = q[31:0];
        end
      end
      3'd5: m_hi = a;
      3'd6: m_lo = a;
      default: lat = 0;
    endcase
  endtask
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    int lat, n;
    model(op, a, b, lat);
    @(posedge clk); #1 md_op = op; src_a = a; src_b = b;
    @(posedge clk); #1 md_op = '0; src_a = $urandom; src_b = $urandom;
    n = 0;
    @(negedge clk);
    while (stallreq_from_ex === 1'b1 && n < 100) begin n++; @(negedge clk); end
    chk({tag, ".lat"}, n, lat);
    chk({tag, ".busy"}, md_busy, (op >= 3'd1 && op <= 3'd4));
    @(negedge clk);
    chk({tag, ".hi"}, hi, m_hi);
    chk({tag, ".lo"}, lo, m_lo);
  endtask
  initial begin
    logic [2:0] op;
    logic [31:0] a, b;
    #12;
    chk("rst.hi", hi, 0);
    chk("rst.lo", lo, 0);
    chk("rst.stallreq", stallreq_from_ex, 0);
    chk("rst.busy", md_busy, 0);
    rst = 1'b1;
    do_op(3'd1, 32'hFFFFFFFF, 32'd2, "mult");
    do_op(3'd4, 32'd100, 32'd7, "divu");
    do_op(3'd3, -32'sd7, 32'd2, "div_neg");
    do_op(3'd3, 32'd5, 32'd0, "div_zero");
    do_op(3'd3, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
    for (int i = 0; i < 25; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      do_op(op, a, b, $sformatf("rnd%0d", i));
    end
    // Flush on BUSY cycle 10 of a divide
    @(posedge clk); #1 md_op = 3'd3; src_a = 32'd1000; src_b = 32'd3;
    @(posedge clk); #1 md_op = '0;
    @(negedge clk);
    chk("flush.issue", stallreq_from_ex, 1);
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    #1 chk("flush.stallreq", stallreq_from_ex, 0);
    chk("flush.busy_in", md_busy, 1);
    @(posedge clk); #1 flush = 1'b0;
    chk("flush.idle", md_busy, 0);
    repeat (40) @(negedge clk);
    chk("flush.hi", hi, m_hi);
    chk("flush.lo", lo, m_lo);
    chk("flush.quiet", stallreq_from_ex, 0);
    // Asynchronous reset in the middle of a divide
    do_op(3'd5, 32'hDEAD, 32'd0, "mthi");
    do_op(3'd6, 32'hBEEF, 32'd0, "mtlo");
    @(posedge clk); #1 md_op = 3'd4; src_a = 32'd999; src_b = 32'd5;
    @(posedge clk); #1 md_op = '0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    m_hi = '0;
    m_lo = '0;
    #1 chk("arst.hi", hi, 0);
    chk("arst.lo", lo, 0);
    chk("arst.stallreq", stallreq_from_ex, 0);
    chk("arst.busy", md_busy, 0);
    #2 rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("arst.lost_hi", hi, 0);
    chk("arst.lost_lo", lo, 0);
    chk("arst.lost_busy", md_busy, 0);
    // MTHI held by a MEM stall, then MULTU held by an external stall in DONE
    @(posedge clk); #1 md_op = 3'd5; src_a = 32'h1234;
    @(posedge clk); #1 ext = 6'b011111; md_op = 3'd2; src_a = 32'd3; src_b = 32'd4;
    @(negedge clk);
    chk("mt.stallreq", stallreq_from_ex, 0);
    chk("mt.busy", md_busy, 0);
    @(negedge clk);
    chk("mt.hi1", hi, 32'h1234);
    @(negedge clk);
    chk("mt.hi2", hi, 32'h1234);
    ext = '0;
    @(posedge clk); #1 md_op = '0;
    @(negedge clk);
    chk("mu.issue", stallreq_from_ex, 1);
    @(negedge clk);
    chk("mu.busy_stall", stallreq_from_ex, 1);
    @(negedge clk);
    chk("mu.done_stall", stallreq_from_ex, 0);
    chk("mu.done_busy", md_busy, 1);
    ext = 6'b011111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("mu.hold_stall%0d", i), stallreq_from_ex, 0);
      chk($sformatf("mu.hold_busy%0d", i), md_busy, 0);
    end
    chk("mu.hi", hi, 0);
    chk("mu.lo", lo, 12);
    ext = '0;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
